// File: rtl/memory_stage_if.sv
// Shared control word type and the data-memory req/ack bus used by memory_stage.
package memory_stage_pkg;

    typedef struct packed {
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic [2:0] funct3;
    } control_type;

endpackage

// Data-memory handshake: the stage is master, the memory is slave.
interface memory_stage_if;

    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;

    modport master (
        output dmem_req,
        output dmem_we,
        output dmem_addr,
        output dmem_be,
        output dmem_wdata,
        input  dmem_ack,
        input  dmem_rdata
    );

    modport slave (
        input  dmem_req,
        input  dmem_we,
        input  dmem_addr,
        input  dmem_be,
        input  dmem_wdata,
        output dmem_ack,
        output dmem_rdata
    );

endinterface

// File: rtl/memory_stage.sv
// Memory pipeline stage: byte/half/word loads and stores over a req/ack bus,
// misalignment and timeout detection, and the MEM/WB pipeline register.
module memory_stage
    import memory_stage_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  valid_in,
    input  logic [31:0]           alu_data_in,
    input  logic [31:0]           memory_data_in,
    input  control_type           control_in,
    input  logic                  compflg_in,
    output logic                  stall,
    memory_stage_if.master        dmem,
    output logic                  valid_out,
    output logic [31:0]           alu_data_out,
    output logic [31:0]           mem_data_out,
    output control_type           control_out,
    output logic                  compflg_out,
    output logic                  misaligned_flag,
    output logic                  bus_error_flag
);

    typedef enum logic {IDLE, ACCESS} state_t;

    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           state;
    logic [CNT_W-1:0] counter;

    logic        mem_op;
    logic        misaligned;
    logic        timeout;
    logic [1:0]  byte_sel;
    logic [7:0]  load_byte;
    logic [15:0] load_half;
    logic [31:0] load_ext;
    logic [31:0] store_data;
    logic [3:0]  store_be;

    logic [31:0] next_mem_data;
    logic        next_valid;
    logic        next_misaligned;
    logic        next_bus_error;
    control_type next_control;

    // Classify the incoming instruction and detect misaligned halfword/word accesses.
    always_comb begin
        byte_sel   = alu_data_in[1:0];
        mem_op     = valid_in & (control_in.mem_read | control_in.mem_write);
        misaligned = 1'b0;
        case (control_in.funct3)
            3'b001, 3'b101: misaligned = byte_sel[0];
            3'b010:         misaligned = (byte_sel != 2'b00);
            default:        misaligned = 1'b0;
        endcase
    end

    // Pick the addressed byte/half out of the read word and extend it.
    always_comb begin
        load_byte = dmem.dmem_rdata[{byte_sel, 3'b000} +: 8];
        load_half = byte_sel[1] ? dmem.dmem_rdata[31:16] : dmem.dmem_rdata[15:0];
        case (control_in.funct3)
            3'b000:  load_ext = {{24{load_byte[7]}}, load_byte};
            3'b001:  load_ext = {{16{load_half[15]}}, load_half};
            3'b100:  load_ext = {24'h0, load_byte};
            3'b101:  load_ext = {16'h0, load_half};
            default: load_ext = dmem.dmem_rdata;
        endcase
    end

    // Replicate store data across lanes and enable only the addressed bytes.
    always_comb begin
        case (control_in.funct3)
            3'b000: begin
                store_be   = 4'b0001 << byte_sel;
                store_data = {4{memory_data_in[7:0]}};
            end
            3'b001: begin
                store_be   = 4'b0011 << byte_sel;
                store_data = {2{memory_data_in[15:0]}};
            end
            default: begin
                store_be   = 4'b1111;
                store_data = memory_data_in;
            end
        endcase
    end

    // Bus drive and stall; the timeout cycle still shows req but lets MEM/WB load the error.
    always_comb begin
        timeout         = (state == ACCESS) && !dmem.dmem_ack && (counter == LAST_COUNT);
        dmem.dmem_req   = !reset && (state == ACCESS);
        dmem.dmem_we    = control_in.mem_write;
        dmem.dmem_addr  = {alu_data_in[31:2], 2'b00};
        dmem.dmem_be    = control_in.mem_write ? store_be : 4'b1111;
        dmem.dmem_wdata = store_data;
        if (reset) begin
            stall = 1'b0;
        end else if (state == IDLE) begin
            stall = mem_op && !misaligned;
        end else begin
            stall = !dmem.dmem_ack && !timeout;
        end
    end

    // Values MEM/WB takes whenever the stage is not stalled.
    always_comb begin
        next_valid      = valid_in;
        next_mem_data   = 32'h0;
        next_misaligned = 1'b0;
        next_bus_error  = 1'b0;
        next_control    = control_in;
        if (state == ACCESS) begin
            next_valid = 1'b1;
            if (dmem.dmem_ack) begin
                if (!control_in.mem_write) begin
                    next_mem_data = load_ext;
                end
            end else begin
                next_bus_error         = 1'b1;
                next_control.reg_write = 1'b0;
            end
        end else if (mem_op && misaligned) begin
            next_misaligned        = 1'b1;
            next_control.reg_write = 1'b0;
        end
    end

    // Access FSM, timeout counter and MEM/WB register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= IDLE;
            counter         <= '0;
            valid_out       <= 1'b0;
            alu_data_out    <= 32'h0;
            mem_data_out    <= 32'h0;
            control_out     <= '0;
            compflg_out     <= 1'b0;
            misaligned_flag <= 1'b0;
            bus_error_flag  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (mem_op && !misaligned) begin
                        state   <= ACCESS;
                        counter <= '0;
                    end
                end
                ACCESS: begin
                    if (dmem.dmem_ack || timeout) begin
                        state <= IDLE;
                    end else begin
                        counter <= counter + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
            if (!stall) begin
                valid_out       <= next_valid;
                alu_data_out    <= alu_data_in;
                mem_data_out    <= next_mem_data;
                control_out     <= next_control;
                compflg_out     <= compflg_in;
                misaligned_flag <= next_misaligned;
                bus_error_flag  <= next_bus_error;
            end
        end
    end

endmodule
